// File: rtl/vpu_src_fetch.sv
// rtl/vpu_src_fetch.sv - decodes a vector instruction and issues per-bank SRAM reads for its source operands.
// Optional build macro VPU_SRC_FETCH_MERGE_EN: same bank+row sources share one read.
module vpu_src_fetch #(
  parameter int SRC_CNT    = 3,
  parameter int BANK_CNT   = 4,
  parameter int BANK_DEPTH = 1024,
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  instr_valid_i,
  output logic                                  instr_ready_o,
  input  logic [8+ADDR_WIDTH*(SRC_CNT+1)-1:0]   instr_i,
  output logic [BANK_CNT-1:0]                   rd_req_o,
  output logic [BANK_CNT*$clog2(BANK_DEPTH)-1:0] rd_addr_o,
  output logic [BANK_CNT*SRC_CNT-1:0]           rd_src_mask_o,
  output logic                                  op_valid_o,
  input  logic                                  op_ready_i,
  output logic [7:0]                            op_opcode_o,
  output logic [$clog2(BANK_CNT)-1:0]           op_dst_bank_o,
  output logic [$clog2(BANK_DEPTH)-1:0]         op_dst_row_o,
  output logic                                  op_err_o
);

  localparam int INSTR_W = 8 + ADDR_WIDTH*(SRC_CNT+1);
  localparam int OFF_W   = $clog2(DATA_WIDTH);
  localparam int BANK_W  = $clog2(BANK_CNT);
  localparam int ROW_W   = $clog2(BANK_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]         state;
  logic [INSTR_W-1:0] instr_q;
  logic [SRC_CNT-1:0] pending;
  logic               err_q;

  logic [2:0]         acc_cnt;
  logic [SRC_CNT-1:0] acc_mask;
  logic [SRC_CNT-1:0] served;
  logic [SRC_CNT-1:0] pending_next;
  logic [BANK_W-1:0]  src_bank [SRC_CNT];
  logic [ROW_W-1:0]   src_row  [SRC_CNT];

  function automatic logic [2:0] src_count(input logic [7:0] op);
    case (op)
      8'h05, 8'h0C, 8'h0D:                      src_count = 3'd1;
      8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07,
      8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0E:        src_count = 3'd2;
      default:                                  src_count = 3'd0;
    endcase
  endfunction

  always_comb begin
    acc_cnt  = src_count(instr_i[INSTR_W-1 -: 8]);
    acc_mask = '0;
    for (int i = 0; i < SRC_CNT; i++) acc_mask[i] = (i < int'(acc_cnt));
  end

  // Source i sits just above dst0, i.e. at field index i+1.
  always_comb begin
    for (int i = 0; i < SRC_CNT; i++) begin
      src_bank[i] = instr_q[ADDR_WIDTH*(i+1) + OFF_W +: BANK_W];
      src_row[i]  = instr_q[ADDR_WIDTH*(i+1) + OFF_W + BANK_W +: ROW_W];
    end
  end

  always_comb begin
    logic               found;
    logic [ROW_W-1:0]   row_sel;
    logic [SRC_CNT-1:0] m;
    rd_req_o      = '0;
    rd_addr_o     = '0;
    rd_src_mask_o = '0;
    served        = '0;
    for (int b = 0; b < BANK_CNT; b++) begin
      found   = 1'b0;
      row_sel = '0;
      m       = '0;
      // Lowest-index pending source wins the bank this cycle.
      for (int i = 0; i < SRC_CNT; i++) begin
        if (state == ISSUE && pending[i] && src_bank[i] == BANK_W'(b)) begin
          if (!found) begin
            found   = 1'b1;
            row_sel = src_row[i];
            m[i]    = 1'b1;
          end
`ifdef VPU_SRC_FETCH_MERGE_EN
          else if (src_row[i] == row_sel) begin
            m[i] = 1'b1;
          end
`endif
        end
      end
      rd_req_o[b]                        = found;
      rd_addr_o[b*ROW_W +: ROW_W]        = row_sel;
      rd_src_mask_o[b*SRC_CNT +: SRC_CNT] = m;
      served                             = served | m;
    end
  end

  assign pending_next = pending & ~served;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      instr_q <= '0;
      pending <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid_i) begin
            instr_q <= instr_i;
            pending <= acc_mask;
            err_q   <= (acc_cnt == 3'd0);
            state   <= (acc_cnt == 3'd0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          pending <= pending_next;
          if (pending_next == '0) state <= DONE;
        end
        DONE: begin
          if (op_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ready is masked by reset so every output reads 0 while rst_n is low.
  assign instr_ready_o = (state == IDLE) && rst_n;
  assign op_valid_o    = (state == DONE);
  assign op_opcode_o   = instr_q[INSTR_W-1 -: 8];
  assign op_dst_bank_o = instr_q[OFF_W +: BANK_W];
  assign op_dst_row_o  = instr_q[OFF_W + BANK_W +: ROW_W];
  assign op_err_o      = err_q;

  logic unused_bits;
  assign unused_bits = ^instr_q;

endmodule

// File: tb/tb_vpu_src_fetch.sv
// tb/tb_vpu_src_fetch.sv - directed table-driven bench for vpu_src_fetch.
module tb_vpu_src_fetch;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [135:0]  instr = '0;
  logic [3:0]    rd_req;
  logic [39:0]   rd_addr;
  logic [11:0]   rd_src_mask;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [7:0]    op_opcode;
  logic [1:0]    op_dst_bank;
  logic [9:0]    op_dst_row;
  logic          op_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_src_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
    .rd_req_o(rd_req), .rd_addr_o(rd_addr), .rd_src_mask_o(rd_src_mask),
    .op_valid_o(op_valid), .op_ready_i(op_ready), .op_opcode_o(op_opcode),
    .op_dst_bank_o(op_dst_bank), .op_dst_row_o(op_dst_row), .op_err_o(op_err)
  );

  typedef struct {
    logic [7:0]        op;
    logic [31:0]       s0, s1, s2, dst;
    int                n;
    logic [1:0][3:0]   req;
    logic [1:0][11:0]  mask;
    logic [1:0][39:0]  addr;
    logic              err;
    logic [1:0]        dbank;
    logic [9:0]        drow;
    int                hold;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] keep_of(input logic [3:0] req);
    logic [39:0] k = '0;
    for (int b = 0; b < 4; b++) if (req[b]) k[b*10 +: 10] = 10'h3FF;
    return k;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [39:0] keep;
    @(negedge clk);
    chk($sformatf("v%0d_ready", idx), instr_ready, 1);
    instr_valid = 1'b1;
    instr = {v.op, v.s2, v.s1, v.s0, v.dst};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int c = 1; c <= v.n + 1; c++) begin
      @(negedge clk);
      if (c <= v.n) begin
        keep = keep_of(v.req[c-1]);
        chk($sformatf("v%0d_c%0d_req", idx, c), rd_req, v.req[c-1]);
        chk($sformatf("v%0d_c%0d_mask", idx, c), rd_src_mask, v.mask[c-1]);
        chk($sformatf("v%0d_c%0d_addr", idx, c), rd_addr & keep, v.addr[c-1]);
        chk($sformatf("v%0d_c%0d_valid", idx, c), op_valid, 0);
      end else begin
        chk($sformatf("v%0d_done_req", idx), rd_req, 0);
        chk($sformatf("v%0d_done_mask", idx), rd_src_mask, 0);
        chk($sformatf("v%0d_done_valid", idx), op_valid, 1);
        chk($sformatf("v%0d_done_err", idx), op_err, v.err);
        chk($sformatf("v%0d_done_opc", idx), op_opcode, v.op);
        chk($sformatf("v%0d_done_dbank", idx), op_dst_bank, v.dbank);
        chk($sformatf("v%0d_done_drow", idx), op_dst_row, v.drow);
        chk($sformatf("v%0d_done_rdy", idx), instr_ready, 0);
      end
    end
    // Stall downstream: outputs must hold and no new instruction may enter.
    for (int h = 0; h < v.hold; h++) begin
      instr_valid = 1'b1;
      instr = {8'h07, 32'h0, 32'h400, 32'h200, 32'h0};
      @(negedge clk);
      chk($sformatf("v%0d_h%0d_valid", idx, h), op_valid, 1);
      chk($sformatf("v%0d_h%0d_opc", idx, h), op_opcode, v.op);
      chk($sformatf("v%0d_h%0d_drow", idx, h), op_dst_row, v.drow);
      chk($sformatf("v%0d_h%0d_req", idx, h), rd_req, 0);
      chk($sformatf("v%0d_h%0d_rdy", idx, h), instr_ready, 0);
    end
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
    instr_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h07, 32'h200, 32'h400, 32'h200, 32'hA00, 1,
                {4'h0, 4'h6}, {12'h0, 12'h088}, {40'h0, 40'h0}, 1'b0, 2'd1, 10'd1, 0};
    vecs[1] = '{8'h09, 32'h200, 32'hA00, 32'h0, 32'h0, 2,
                {4'h2, 4'h2}, {12'h010, 12'h008}, {40'h400, 40'h0}, 1'b0, 2'd0, 10'd0, 0};
`ifdef VPU_SRC_FETCH_MERGE_EN
    vecs[2] = '{8'h07, 32'h600, 32'h600, 32'h0, 32'h0, 1,
                {4'h0, 4'h8}, {12'h0, 12'h600}, {40'h0, 40'h0}, 1'b0, 2'd0, 10'd0, 0};
`else
    vecs[2] = '{8'h07, 32'h600, 32'h600, 32'h0, 32'h0, 2,
                {4'h8, 4'h8}, {12'h400, 12'h200}, {40'h0, 40'h0}, 1'b0, 2'd0, 10'd0, 0};
`endif
    vecs[3] = '{8'hFF, 32'h200, 32'h400, 32'h600, 32'h1E00, 0,
                {4'h0, 4'h0}, {12'h0, 12'h0}, {40'h0, 40'h0}, 1'b1, 2'd3, 10'd3, 0};
    vecs[4] = '{8'h0C, 32'h400, 32'h200, 32'h0, 32'h0, 1,
                {4'h0, 4'h4}, {12'h0, 12'h040}, {40'h0, 40'h0}, 1'b0, 2'd0, 10'd0, 5};
    vecs[5] = '{8'h0E, 32'hFFE00200, 32'h001FFE00, 32'h0, 32'h0, 1,
                {4'h0, 4'hA}, {12'h0, 12'h408}, {40'h0, 40'hFFC0000000}, 1'b0, 2'd0, 10'd0, 0};
    vecs[6] = '{8'h00, 32'h200, 32'h400, 32'h0, 32'h0, 0,
                {4'h0, 4'h0}, {12'h0, 12'h0}, {40'h0, 40'h0}, 1'b1, 2'd0, 10'd0, 0};

    #12;
    chk("rst_ready", instr_ready, 0);
    chk("rst_req", rd_req, 0);
    chk("rst_valid", op_valid, 0);
    chk("rst_opc", op_opcode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", instr_ready, 1);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Reset mid-ISSUE of the two-cycle FMUL case.
    @(negedge clk);
    instr_valid = 1'b1;
    instr = {8'h09, 32'h0, 32'hA00, 32'h200, 32'h0};
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("rstm_c1_req", rd_req, 4'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_req", rd_req, 0);
    chk("rstm_mask", rd_src_mask, 0);
    chk("rstm_valid", op_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstm_after%0d_valid", c), op_valid, 0);
      chk($sformatf("rstm_after%0d_req", c), rd_req, 0);
    end
    run_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
